iram_stream_loader: RTL and testbench

//  Parametrised instruction memory for the downsampling processor, successor to the fixed 256x8 iRAM.

---
 rtl/iram_pkg.sv | 28 ++
 rtl/iram_bank.sv | 30 +++
 rtl/iram_stream_loader.sv | 115 +++++++++++
 tb/tb_iram_stream_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Shared types and elaboration helpers for the streamed instruction memory.
// Holds the FSM encoding, the instr output source select and the default NOP word.
package iram_pkg;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

    // Source currently presented on instr. SRC_ZERO covers the time between reset
    // and the first fetch, when the RAM read register is still undefined.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_NOP,
        SRC_MEM
    } instr_src_e;

    localparam int NOP_DEFAULT = 0;

    function automatic bit depth_fits(input int depth, input int addr_w);
        return (depth >= 1) && (depth <= (1 << addr_w));
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iram_bank.sv
// Simple dual-port instruction RAM: one synchronous write port, one synchronous read port.
// The read register holds its value when rd_en is low.
module iram_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset; clearing a RAM needs a
    // per-word write loop and prevents mapping onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/iram_stream_loader.sv
// Instruction memory loaded at run time over a valid/ready byte stream.
// LOAD/RUN mode FSM, one-cycle fetch with valid strobe and sticky out-of-range flag.
module iram_stream_loader
    import iram_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 8,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    input  logic              FETCH,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              run,
    output logic              addr_err,
    output logic [ADDR_W:0]   ld_count
);

    localparam int IDX_W = idx_width(DEPTH);

    if (!depth_fits(DEPTH, ADDR_W)) begin : g_depth_check
        $error("iram_stream_loader: DEPTH must be in 1..2**ADDR_W");
    end

    state_e            state_q, state_d;
    instr_src_e        src_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   ld_count_q;
    logic [DATA_W-1:0] rd_data;
    logic              xfer, last_slot, restart, fetch_en, in_range;

    assign ld_ready  = (state_q == ST_LOAD);
    assign run       = (state_q == ST_RUN);
    assign xfer      = ld_valid & ld_ready;
    assign last_slot = (wr_ptr == ADDR_W'(DEPTH - 1));
    assign restart   = run & reload;
    assign fetch_en  = run & FETCH;
    assign in_range  = ({1'b0, iAddr} < (ADDR_W + 1)'(DEPTH));
    assign ld_count  = ld_count_q;

    // NOTE: every variable assigned in always_comb gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: if (xfer && (ld_last || last_slot)) state_d = ST_RUN;
            ST_RUN:  if (reload)                         state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    // wr_ptr stops at the last slot: the FSM leaves LOAD on that transfer anyway.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            wr_ptr     <= '0;
            ld_count_q <= '0;
        end else if (xfer) begin
            if (!last_slot) wr_ptr <= wr_ptr + 1'b1;
            if (ld_count_q < (ADDR_W + 1)'(DEPTH)) ld_count_q <= ld_count_q + 1'b1;
        end
    end

    // A fetch issued together with reload still completes; the flag clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            src_q       <= SRC_ZERO;
            addr_err    <= 1'b0;
        end else begin
            instr_valid <= fetch_en;
            if (fetch_en) src_q <= in_range ? SRC_MEM : SRC_NOP;
            if (restart)                     addr_err <= 1'b0;
            else if (fetch_en && !in_range)  addr_err <= 1'b1;
        end
    end

    always_comb begin
        instr = '0;
        unique case (src_q)
            SRC_MEM:  instr = rd_data;
            SRC_NOP:  instr = NOP;
            default:  instr = '0;
        endcase
    end

    iram_bank #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk    (clk),
        .wr_en  (xfer),
        .wr_addr(wr_ptr[IDX_W-1:0]),
        .wr_data(ld_data),
        .rd_en  (fetch_en & in_range),
        .rd_addr(iAddr[IDX_W-1:0]),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_iram_stream_loader.sv
// Directed bench for iram_stream_loader (DEPTH=16): fetch results go through a
// scoreboard queue checked by a monitor; mode/counter outputs are checked inline.
module tb_iram_stream_loader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset, ld_valid, ld_last, reload, FETCH;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] iAddr;
    logic              ld_ready, instr_valid, run, addr_err;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W:0]   ld_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q [$];

    iram_stream_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .NOP   (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .reload     (reload),
        .FETCH      (FETCH),
        .iAddr      (iAddr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .run        (run),
        .addr_err   (addr_err),
        .ld_count   (ld_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every instr_valid strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fetch: got instr %0h with nothing expected", instr);
            end else begin
                check("fetch_instr", 32'(instr), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] data, input logic last);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] addr, input logic [7:0] exp);
        FETCH = 1'b1;
        iAddr = addr;
        exp_q.push_back(exp);
        step();
        FETCH = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img5 [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

        reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        reload = 1'b0; FETCH = 1'b0; iAddr = '0;
        repeat (2) step();
        reset = 1'b0;
        check("rst_run", 32'(run), 0);
        check("rst_ld_ready", 32'(ld_ready), 1);
        check("rst_ld_count", 32'(ld_count), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_addr_err", 32'(addr_err), 0);

        // Five-word image, last flagged on the fifth.
        for (int i = 0; i < 4; i++) send(img5[i], 1'b0);
        check("t1_run_before_last", 32'(run), 0);
        send(img5[4], 1'b1);
        check("t1_run", 32'(run), 1);
        check("t1_ld_ready", 32'(ld_ready), 0);
        check("t1_ld_count", 32'(ld_count), 5);

        // Back-to-back fetches starting in the first RUN cycle.
        for (int i = 0; i < 5; i++) fetch(8'(i), img5[i]);
        step();
        check("t2_instr_held", 32'(instr), 32'h05);
        check("t2_valid_dropped", 32'(instr_valid), 0);

        // Back to LOAD; a fetch there is ignored.
        pulse_reload();
        check("t5_run_after_reload", 32'(run), 0);
        check("t5_ld_ready", 32'(ld_ready), 1);
        check("t5_ld_count_clear", 32'(ld_count), 0);
        FETCH = 1'b1; iAddr = 8'd0;
        step();
        FETCH = 1'b0;
        check("t5_load_fetch_valid", 32'(instr_valid), 0);
        check("t5_load_fetch_instr", 32'(instr), 32'h05);

        // Reset partway through an image.
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
        check("t5_partial_count", 32'(ld_count), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_reset_count", 32'(ld_count), 0);
        check("t5_reset_run", 32'(run), 0);
        check("t5_reset_ld_ready", 32'(ld_ready), 1);
        check("t5_reset_instr", 32'(instr), 0);

        // Fill all 16 words with no ld_last.
        for (int i = 0; i < 15; i++) send(8'h10 + 8'(i), 1'b0);
        check("t3_run_at_15", 32'(run), 0);
        check("t3_count_15", 32'(ld_count), 15);
        send(8'h1F, 1'b0);
        check("t3_run_full", 32'(run), 1);
        check("t3_count_full", 32'(ld_count), 16);
        check("t3_ld_ready_full", 32'(ld_ready), 0);
        ld_valid = 1'b1; ld_data = 8'hEE;
        step();
        check("t3_stall_ready", 32'(ld_ready), 0);
        check("t3_stall_count", 32'(ld_count), 16);
        step();
        ld_valid = 1'b0;
        fetch(8'd15, 8'h1F);
        fetch(8'd0, 8'h10);
        check("t3_no_err", 32'(addr_err), 0);

        // Out-of-range fetches return NOP and set the sticky flag.
        fetch(8'd20, 8'h00);
        check("t4_err_set", 32'(addr_err), 1);
        fetch(8'd3, 8'h13);
        check("t4_err_sticky", 32'(addr_err), 1);
        fetch(8'd16, 8'h00);
        check("t4_err_boundary", 32'(addr_err), 1);
        pulse_reload();
        check("t4_err_cleared", 32'(addr_err), 0);
        check("t4_run_cleared", 32'(run), 0);

        // reload and FETCH in the same RUN cycle.
        send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b1);
        check("t6_run", 32'(run), 1);
        reload = 1'b1; FETCH = 1'b1; iAddr = 8'd1;
        exp_q.push_back(8'h22);
        step();
        reload = 1'b0; FETCH = 1'b0;
        check("t6_valid", 32'(instr_valid), 1);
        check("t6_run_off", 32'(run), 0);
        check("t6_ld_ready", 32'(ld_ready), 1);
        send(8'h77, 1'b1);
        fetch(8'd0, 8'h77);
        fetch(8'd1, 8'h22);
        check("t6_stale_no_err", 32'(addr_err), 0);

        repeat (2) step();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
